// File: rtl/mult_seq_ctrl.sv
// Radix-2 shift-add multiply sequencer for mult/multu in EX.
// Freezes the pipeline while iterating and presents the product for one cycle.
module mult_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               abort,
  output logic               pipe_reg_en,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               busy_q, done_q;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] acc_nx;

  // Magnitude of the most negative value wraps to 2^(W-1), read unsigned.
  assign mag_a = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign mag_b = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
  assign acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    neg_d       = neg_q;
    prod_d      = prod_q;
    pipe_reg_en = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          pipe_reg_en = 1'b0;
          mcand_d     = {{WIDTH{1'b0}}, mag_a};
          mplier_d    = mag_b;
          neg_d       = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          acc_d       = '0;
          count_d     = CNT_INIT;
          state_d     = RUN;
        end
      end
      RUN: begin
        pipe_reg_en = 1'b0;
        if (abort) begin
          state_d = IDLE;
        end else begin
          acc_d    = acc_nx;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q - CNT_ONE;
          if (count_q == CNT_ONE) begin
            prod_d  = neg_q ? -acc_nx : acc_nx;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (reset) begin
      pipe_reg_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      prod_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      prod_q   <= prod_d;
      busy_q   <= (state_d == RUN);
      done_q   <= (state_d == DONE);
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule
